// File: rtl/uart_rx_byte_counter.sv
// uart_rx_byte_counter
// Counts bytes delivered by the UART1 receiver and drives the running count
// onto the RX-counter PIO input port. Software reaches the block through an
// Avalon-MM slave to enable counting, clear the counters, choose saturate or
// wrap mode, read sticky overflow/error status and read a framing-error count.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   address    Avalon word address (0 COUNT, 1 CONTROL, 2 STATUS, 3 ERRCOUNT)
//   chipselect Avalon slave select
//   write_n    Avalon write strobe, active low
//   writedata  Avalon write data
//   readdata   registered, zero-extended read data (1-cycle latency)
//   rx_strobe  receiver byte-ready; each rising edge counts one byte
//   rx_error   receiver framing/parity error; each rising edge counts one error
//   count_out  current byte count to the PIO in_port
module uart_rx_byte_counter #(
  parameter int unsigned WIDTH        = 10,
  parameter logic        RESET_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             rx_strobe,
  input  logic             rx_error,
  output logic [WIDTH-1:0] count_out
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADDR_COUNT    = 2'd0;
  localparam logic [1:0] ADDR_CONTROL  = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_ERRCOUNT = 2'd3;

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

  // State
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] errcount_q;
  logic             enable_q;
  logic             saturate_q;
  logic             overflow_q;
  logic             error_seen_q;
  logic             rx_strobe_q;
  logic             rx_error_q;

  // Next-state
  logic [WIDTH-1:0]  count_d;
  logic [WIDTH-1:0]  errcount_d;
  logic              enable_d;
  logic              saturate_d;
  logic              overflow_d;
  logic              error_seen_d;
  logic [DATA_W-1:0] read_mux_c;

  // Decoded strobes
  logic wr_c;
  logic wr_control_c;
  logic wr_status_c;
  logic wr_errcount_c;
  logic clear_c;
  logic rx_rise_c;
  logic err_rise_c;
  logic byte_event_c;
  logic err_event_c;
  logic at_max_c;

  // Only bits [2:0] of writedata carry meaning; fold the rest away.
  logic unused_wdata;
  assign unused_wdata = ^writedata[DATA_W-1:3];

  // Bus write decode
  assign wr_c          = chipselect & ~write_n;
  assign wr_control_c  = wr_c & (address == ADDR_CONTROL);
  assign wr_status_c   = wr_c & (address == ADDR_STATUS);
  assign wr_errcount_c = wr_c & (address == ADDR_ERRCOUNT);
  assign clear_c       = wr_control_c & writedata[2];

  // Rising-edge detect against last cycle's input level
  assign rx_rise_c  = rx_strobe & ~rx_strobe_q;
  assign err_rise_c = rx_error  & ~rx_error_q;

  // Events qualified by the enable in force during this cycle
  assign byte_event_c = enable_q & rx_rise_c;
  assign err_event_c  = enable_q & err_rise_c;
  assign at_max_c     = (count_q == COUNT_MAX);

  // Byte counter: clear beats increment; at max, wrap or hold per mode
  always_comb begin
    count_d = count_q;
    if (clear_c) begin
      count_d = '0;
    end else if (byte_event_c) begin
      if (!at_max_c) begin
        count_d = count_q + WIDTH'(1);
      end else if (!saturate_q) begin
        count_d = '0;
      end
    end
  end

  // Error counter: always wraps; any write to its address or a clear zeroes it
  always_comb begin
    errcount_d = errcount_q;
    if (clear_c || wr_errcount_c) begin
      errcount_d = '0;
    end else if (err_event_c) begin
      errcount_d = errcount_q + WIDTH'(1);
    end
  end

  // Control bits: a write lands next cycle, so this cycle's events use old values
  always_comb begin
    enable_d   = enable_q;
    saturate_d = saturate_q;
    if (wr_control_c) begin
      enable_d   = writedata[0];
      saturate_d = writedata[1];
    end
  end

  // Sticky status: a new set in the same cycle outranks a W1C
  always_comb begin
    overflow_d   = overflow_q;
    error_seen_d = error_seen_q;
    if (wr_status_c && writedata[0]) begin
      overflow_d = 1'b0;
    end
    if (wr_status_c && writedata[1]) begin
      error_seen_d = 1'b0;
    end
    if (byte_event_c && at_max_c) begin
      overflow_d = 1'b1;
    end
    if (err_event_c) begin
      error_seen_d = 1'b1;
    end
  end

  // Read mux over current (pre-update) register values
  always_comb begin
    read_mux_c = '0;
    case (address)
      ADDR_COUNT:    read_mux_c = DATA_W'(count_q);
      ADDR_CONTROL:  read_mux_c = {30'd0, saturate_q, enable_q};
      ADDR_STATUS:   read_mux_c = {30'd0, error_seen_q, overflow_q};
      ADDR_ERRCOUNT: read_mux_c = DATA_W'(errcount_q);
      default:       read_mux_c = '0;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      errcount_q   <= '0;
      enable_q     <= RESET_ENABLE;
      saturate_q   <= 1'b0;
      overflow_q   <= 1'b0;
      error_seen_q <= 1'b0;
      rx_strobe_q  <= 1'b0;
      rx_error_q   <= 1'b0;
      readdata     <= '0;
    end else begin
      count_q      <= count_d;
      errcount_q   <= errcount_d;
      enable_q     <= enable_d;
      saturate_q   <= saturate_d;
      overflow_q   <= overflow_d;
      error_seen_q <= error_seen_d;
      rx_strobe_q  <= rx_strobe;
      rx_error_q   <= rx_error;
      readdata     <= read_mux_c;
    end
  end

  // The count register feeds the PIO directly
  assign count_out = count_q;

endmodule
